tl_sensor_cond: RTL and testbench

//  Upstream conditioning stage for the left-turn traffic-light FSM. Takes four raw, asynchronous

---
 rtl/tl_sensor_cond.sv | 163 ++++++++++++++++
 tb/tb_tl_sensor_cond.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/tl_sensor_cond.sv
`default_nettype none
// ============================================================================
//  Module   : tl_sensor_cond
//  Purpose  : Conditioning stage in front of the left-turn traffic-light FSM.
//             It takes four raw asynchronous vehicle sensors and produces the
//             registered traffic inputs Ta/Tal/Tb/Tbl. Each sensor is
//             synchronised (2 flops) and debounced. The lane that is currently
//             green gets a minimum-green hold and a maximum-green cutoff, so
//             one lane cannot starve the others.
//  Ports    : clk                - single clock, rising edge
//             reset_n            - asynchronous active-low reset
//             Sa, Sal, Sb, Sbl   - raw sensors (async): A, A-left, B, B-left
//             q2, q1, q0         - current FSM state (synchronous to clk)
//             Ta, Tal, Tb, Tbl   - registered traffic present/hold outputs
//  Params   : DEB_CYC   - stable synchronised cycles before the debounced
//                         value flips (DEB_CYC < 2**CW)
//             MIN_GREEN - cycles the served lane is forced to 1
//             MAX_GREEN - cycles after which the served lane is forced to 0
//                         (MIN_GREEN < MAX_GREEN < 2**CW)
//             CW        - dwell / debounce counter width
//  Revision : 1.0 - initial release
// ============================================================================
module tl_sensor_cond #(
    parameter int DEB_CYC   = 4,
    parameter int MIN_GREEN = 8,
    parameter int MAX_GREEN = 32,
    parameter int CW        = 6
) (
    input  logic clk,
    input  logic reset_n,
    input  logic Sa,
    input  logic Sal,
    input  logic Sb,
    input  logic Sbl,
    input  logic q2,
    input  logic q1,
    input  logic q0,
    output logic Ta,
    output logic Tal,
    output logic Tb,
    output logic Tbl
);

    localparam logic [CW-1:0] c_deb_last = CW'(DEB_CYC - 1);
    localparam logic [CW-1:0] c_min      = CW'(MIN_GREEN);
    localparam logic [CW-1:0] c_max      = CW'(MAX_GREEN);
    localparam int            c_lanes    = 4;

    // Lane index order used throughout: 0=A, 1=A-left, 2=B, 3=B-left.
    // This matches the {q2,q1} encoding of the green phases.
    logic [c_lanes-1:0] w_raw;
    logic [c_lanes-1:0] w_deb;
    logic [c_lanes-1:0] w_t_next;
    logic [c_lanes-1:0] r_t;
    logic [2:0]         w_q;

    assign w_raw = {Sbl, Sb, Sal, Sa};
    assign w_q   = {q2, q1, q0};

    // ------------------------------------------------------------------------
    // Per-sensor synchroniser and debouncer
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < c_lanes; i++) begin : g_sensor
            logic          r_s1;
            logic          r_s2;
            logic          r_deb;
            logic [CW-1:0] r_cnt;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_s1  <= 1'b0;
                    r_s2  <= 1'b0;
                    r_deb <= 1'b0;
                    r_cnt <= '0;
                end else begin
                    r_s1 <= w_raw[i];
                    r_s2 <= r_s1;
                    if (r_s2 == r_deb) begin
                        // Any return to the current value restarts the count,
                        // so short glitches never accumulate.
                        r_cnt <= '0;
                    end else if (r_cnt == c_deb_last) begin
                        r_deb <= r_s2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            end

            assign w_deb[i] = r_deb;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Dwell counter: cycles spent in the current FSM state
    // ------------------------------------------------------------------------
    logic [2:0]    r_q_prev;
    logic [CW-1:0] r_dwell;
    logic          w_q_change;
    logic [CW-1:0] w_eff_dwell;
    logic [CW-1:0] w_dwell_next;

    assign w_q_change = (w_q != r_q_prev);

    // On the first cycle of a new state the stored dwell still belongs to the
    // previous state, so the effective dwell is forced to zero.
    assign w_eff_dwell = w_q_change ? '0 : r_dwell;

    // Saturate at MAX_GREEN so a long-held state never wraps back below the
    // cutoff and re-asserts the served lane.
    assign w_dwell_next = w_q_change          ? CW'(1) :
                          (r_dwell >= c_max)  ? c_max  :
                                                r_dwell + CW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q_prev <= 3'b000;
            r_dwell  <= '0;
        end else begin
            r_q_prev <= w_q;
            r_dwell  <= w_dwell_next;
        end
    end

    // ------------------------------------------------------------------------
    // Served-lane decode and output registers
    // ------------------------------------------------------------------------
    logic       w_served_valid;
    logic [1:0] w_served_idx;
    logic       w_min_hold;
    logic       w_max_ok;

    // Odd states are yellow phases: nobody is served.
    assign w_served_valid = ~q0;
    assign w_served_idx   = {q2, q1};
    assign w_min_hold     = (w_eff_dwell < c_min);
    assign w_max_ok       = (w_eff_dwell < c_max);

    generate
        for (genvar i = 0; i < c_lanes; i++) begin : g_out
            assign w_t_next[i] = (w_served_valid && (w_served_idx == 2'(i)))
                               ? (w_min_hold | (w_deb[i] & w_max_ok))
                               : w_deb[i];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_t <= '0;
        end else begin
            r_t <= w_t_next;
        end
    end

    assign Ta  = r_t[0];
    assign Tal = r_t[1];
    assign Tb  = r_t[2];
    assign Tbl = r_t[3];

endmodule
`default_nettype wire

// File: tb/tb_tl_sensor_cond.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tl_sensor_cond
//  Purpose  : Self-checking bench for tl_sensor_cond. The stimulus process
//             pushes the hand-computed {Tbl,Tb,Tal,Ta} expected after each
//             clock into a scoreboard queue; a monitor pops and compares on
//             the following falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tl_sensor_cond;

    logic clk = 1'b0;
    logic reset_n;
    logic Sa, Sal, Sb, Sbl;
    logic q2, q1, q0;
    logic Ta, Tal, Tb, Tbl;

    typedef struct {
        logic [3:0] exp;
        string      nm;
        int         tk;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tick_no  = 0;

    tl_sensor_cond #(
        .DEB_CYC  (4),
        .MIN_GREEN(8),
        .MAX_GREEN(32),
        .CW       (6)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .Sa     (Sa),
        .Sal    (Sal),
        .Sb     (Sb),
        .Sbl    (Sbl),
        .q2     (q2),
        .q1     (q1),
        .q0     (q0),
        .Ta     (Ta),
        .Tal    (Tal),
        .Tb     (Tb),
        .Tbl    (Tbl)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] mk(input bit ta, input bit tal, input bit tb, input bit tbl);
        return {tbl, tb, tal, ta};
    endfunction

    task automatic set_q(input logic [2:0] v);
        {q2, q1, q0} = v;
    endtask

    // Wait for a clock edge, then record what the outputs must be after it.
    task automatic tick(input logic [3:0] exp, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        tick_no++;
        e.exp = exp;
        e.nm  = nm;
        e.tk  = tick_no;
        q_exp.push_back(e);
    endtask

    // Monitor: outputs are present every cycle; compare on the falling edge.
    initial begin
        exp_t e;
        logic [3:0] act;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                e   = q_exp.pop_front();
                act = {Tbl, Tb, Tal, Ta};
                n_checks++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s tick %0d: got {Tbl,Tb,Tal,Ta}=%b expected %b",
                             e.nm, e.tk, act, e.exp);
                end
            end
        end
    end

    initial begin
        // ---------------- 1: reset and min-green after release ----------------
        reset_n = 1'b0;
        {Sa, Sal, Sb, Sbl} = 4'b1111;
        set_q(3'b000);
        for (int t = 1; t <= 3; t++) tick(4'b0000, "reset_hold");
        reset_n = 1'b1;
        {Sa, Sal, Sb, Sbl} = 4'b0000;
        for (int t = 1; t <= 12; t++) tick(mk(t <= 8, 0, 0, 0), "t1_min_green");

        // ---------------- 2: debounce on non-served lane A ----------------
        set_q(3'b100);
        Sa = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            if (t == 4) Sa = 1'b0;
            tick(mk(0, 0, t <= 8, 0), "t2_short_pulse");
        end
        Sa = 1'b1;
        for (int t = 1; t <= 10; t++) tick(mk(t >= 7, 0, 0, 0), "t2_rise");
        Sa = 1'b0;
        for (int t = 1; t <= 9; t++) tick(mk(t <= 6, 0, 0, 0), "t2_fall");

        // ---------------- 3: max-green cutoff and restart ----------------
        set_q(3'b001);
        Sb = 1'b1;
        for (int t = 1; t <= 8; t++) tick(mk(0, 0, t >= 7, 0), "t3_yellow");
        set_q(3'b100);
        for (int t = 1; t <= 36; t++) tick(mk(0, 0, t <= 32, 0), "t3_max_green");
        set_q(3'b101);
        for (int t = 1; t <= 2; t++) tick(mk(0, 0, 1, 0), "t3_leave");
        set_q(3'b100);
        for (int t = 1; t <= 3; t++) tick(mk(0, 0, 1, 0), "t3_return");

        // ---------------- 4: phase restart 000->001->010 ----------------
        set_q(3'b000);
        Sb = 1'b0;
        for (int t = 1; t <= 16; t++) begin
            if (t == 3) set_q(3'b001);
            if (t == 5) begin
                set_q(3'b010);
                Sa = 1'b1;
            end
            tick(mk((t <= 2) || (t >= 11), (t >= 5) && (t <= 12), t <= 6, 0), "t4_phase");
        end

        // ---------------- 5: reset pulse mid-debounce ----------------
        Sb = 1'b1;
        for (int t = 1; t <= 3; t++) tick(mk(1, 0, 0, 0), "t5_pre");
        tick(4'b0000, "t5_async_reset");
        reset_n = 1'b0;     // asserted before the falling-edge sample of this tick
        tick(4'b0000, "t5_in_reset");
        reset_n = 1'b1;
        for (int t = 6; t <= 14; t++)
            tick(mk(t >= 12, t <= 13, t >= 12, 0), "t5_after_reset");

        // ---------------- 6: dwell saturation ----------------
        set_q(3'b000);
        Sb = 1'b0;
        for (int t = 1; t <= 200; t++) tick(mk(t <= 32, 0, t <= 6, 0), "t6_saturate");

        @(negedge clk);
        #1;
        n_checks++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q_exp.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
